// File: rtl/instr_encoder.sv
// Packs symbolic MIPS-Lite3 instructions into 32-bit words, queues them, and
// streams them sequentially into instruction memory over a backpressured port.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned IM_AW     = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [15:0]      in_imm,
  input  logic [25:0]      in_target,
  output logic             im_we,
  input  logic             im_ready,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      im_wdata,
  output logic [15:0]      wr_count,
  output logic             err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [IM_AW-1:0] BASE = IM_AW'(BASE_ADDR);

  logic [31:0] mem [DEPTH];
  logic [PW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [31:0] enc_word, head_nxt;
  logic        enc_legal, full, accept, push, pop;

  // Opcode/func packing; addiu deliberately uses 101000 to match this core's decoder.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_kind)
      4'd0:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
      4'd1:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
      4'd2:    enc_word = {6'b001101, in_rs, in_rt, in_imm};
      4'd3:    enc_word = {6'b100011, in_rs, in_rt, in_imm};
      4'd4:    enc_word = {6'b101011, in_rs, in_rt, in_imm};
      4'd5:    enc_word = {6'b000100, in_rs, in_rt, in_imm};
      4'd6:    enc_word = {6'b001111, 5'b00000, in_rt, in_imm};
      4'd7:    enc_word = {6'b001000, in_rs, in_rt, in_imm};
      4'd8:    enc_word = {6'b101000, in_rs, in_rt, in_imm};
      4'd9:    enc_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b101010};
      4'd10:   enc_word = {6'b000010, in_target};
      4'd11:   enc_word = {6'b000011, in_target};
      4'd12:   enc_word = {6'b000000, in_rs, 15'd0, 6'b001000};
      default: enc_legal = 1'b0;
    endcase
  end

  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign in_ready = rst_n && !clr && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && enc_legal;
  assign pop      = im_we && im_ready && !clr;

  // Next head: a word pushed this cycle becomes head when it is the only entry left.
  always_comb begin
    wr_nxt   = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_nxt   = pop ? rd_ptr + 1'b1 : rd_ptr;
    head_nxt = (push && (rd_nxt == wr_ptr)) ? enc_word : mem[rd_nxt[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      im_we    <= 1'b0;
      im_addr  <= BASE;
      im_wdata <= '0;
      wr_count <= '0;
      err      <= 1'b0;
    end else begin
      wr_ptr   <= wr_nxt;
      rd_ptr   <= rd_nxt;
      im_we    <= (wr_nxt != rd_nxt);
      im_wdata <= head_nxt;
      if (pop) begin
        im_addr <= im_addr + 1'b1;
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end
      if (accept && !enc_legal) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected words/addresses,
// monitors pop and compare on each memory write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clr;
  logic        in_valid, w_in_valid, im_ready, w_im_ready;
  logic        in_ready, w_in_ready;
  logic [3:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        im_we, w_im_we, err, w_err;
  logic [9:0]  im_addr;
  logic [1:0]  w_im_addr;
  logic [31:0] im_wdata, w_im_wdata;
  logic [15:0] wr_count, w_wr_count;

  typedef struct {
    logic [31:0] data;
    logic [9:0]  addr;
  } exp_t;

  exp_t q[$];
  exp_t wq[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_addr = 0;
  int   w_exp_addr = 0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(4), .IM_AW(10), .BASE_ADDR(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .im_we(im_we), .im_ready(im_ready), .im_addr(im_addr),
    .im_wdata(im_wdata), .wr_count(wr_count), .err(err)
  );

  instr_encoder #(.DEPTH(4), .IM_AW(2), .BASE_ADDR(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_target(in_target), .im_we(w_im_we), .im_ready(w_im_ready), .im_addr(w_im_addr),
    .im_wdata(w_im_wdata), .wr_count(w_wr_count), .err(w_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one request and hold it until accepted; expectation is queued at accept.
  task automatic send(input bit w, input logic [3:0] k, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [15:0] i,
                      input logic [25:0] g, input logic [31:0] ew);
    int   n = 0;
    bit   rdy;
    exp_t e;
    in_kind = k; in_rs = s; in_rt = t; in_rd = d; in_imm = i; in_target = g;
    if (w) w_in_valid = 1'b1; else in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = w ? w_in_ready : in_ready;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) chk("accept_timeout", 32'(rdy), 32'd1);
    else if (k <= 4'd12) begin
      e.data = ew;
      if (w) begin
        e.addr = 10'(w_exp_addr % 4); w_exp_addr++; wq.push_back(e);
      end else begin
        e.addr = 10'(exp_addr); exp_addr++; q.push_back(e);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; w_in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    chk("in_ready_clr", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    q.delete(); wq.delete();
    exp_addr = 0; w_exp_addr = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Main-instance monitor, including stall-stability tracking.
  bit          prev_stall = 1'b0;
  logic [31:0] ps_data;
  logic [9:0]  ps_addr;
  always @(negedge clk) begin
    exp_t e;
    if (prev_stall) begin
      chk("stall_we", 32'(im_we), 32'd1);
      chk("stall_wdata", im_wdata, ps_data);
      chk("stall_addr", 32'(im_addr), 32'(ps_addr));
    end
    prev_stall = rst_n && !clr && im_we && !im_ready;
    ps_data = im_wdata;
    ps_addr = im_addr;
    if (rst_n && !clr && im_we && im_ready) begin
      if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("wdata", im_wdata, e.data);
        chk("addr", 32'(im_addr), 32'(e.addr));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && !clr && w_im_we && w_im_ready) begin
      if (wq.size() == 0) chk("wrap_unexpected_write", 32'd1, 32'd0);
      else begin
        e = wq.pop_front();
        chk("wrap_wdata", w_im_wdata, e.data);
        chk("wrap_addr", 32'(w_im_addr), 32'(e.addr));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; w_in_valid = 1'b0;
    im_ready = 1'b1; w_im_ready = 1'b1;
    in_kind = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;

    // Reset state
    @(negedge clk);
    chk("in_ready_rst", 32'(in_ready), 32'd0);
    cyc(2);
    @(negedge clk);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_count", 32'(wr_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_release", 32'(in_ready), 32'd1);
    cyc(1);

    // 1: addu latency and count
    send(0, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821);
    @(negedge clk);
    chk("latency_we", 32'(im_we), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("count_1", 32'(wr_count), 32'd1);
    cyc(1);
    do_clr();

    // 2: ori, lw, addiu
    send(0, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0, 32'h34081234);
    send(0, 4'd3, 5'd29, 5'd4, 5'd0, 16'h0008, 26'h0, 32'h8FA40008);
    send(0, 4'd8, 5'd1, 5'd1, 5'd0, 16'h0001, 26'h0, 32'hA0210001);
    cyc(3);
    @(negedge clk);
    chk("count_3", 32'(wr_count), 32'd3);
    cyc(1);
    do_clr();

    // 3: jal, jr (rt/rd ignored), lui (rs forced 0)
    send(0, 4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00, 32'h0C000C00);
    send(0, 4'd12, 5'd31, 5'd5, 5'd7, 16'h0, 26'h0, 32'h03E00008);
    send(0, 4'd6, 5'd9, 5'd3, 5'd0, 16'hBEEF, 26'h0, 32'h3C03BEEF);
    cyc(3);
    do_clr();

    // 4: backpressure, full FIFO, fifth request held
    im_ready = 1'b0;
    send(0, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221823);
    send(0, 4'd9, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 32'h0085302A);
    send(0, 4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 32'h1022FFFF);
    send(0, 4'd7, 5'd2, 5'd3, 5'd0, 16'h0005, 26'h0, 32'h20430005);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    fork
      send(0, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0BFFFFFF);
      begin cyc(4); im_ready = 1'b1; end
    join
    cyc(6);
    @(negedge clk);
    chk("count_5", 32'(wr_count), 32'd5);
    chk("drained_we", 32'(im_we), 32'd0);
    cyc(1);
    do_clr();

    // 5: illegal kind, then legal sw, then clr with queued words
    send(0, 4'd14, 5'd1, 5'd1, 5'd1, 16'h1, 26'h1, 32'h0);
    cyc(2);
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("illegal_no_we", 32'(im_we), 32'd0);
    chk("illegal_addr", 32'(im_addr), 32'd0);
    cyc(1);
    send(0, 4'd4, 5'd2, 5'd3, 5'd0, 16'h0010, 26'h0, 32'hAC430010);
    cyc(3);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("addr_after_sw", 32'(im_addr), 32'd1);
    cyc(1);
    im_ready = 1'b0;
    send(0, 4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h00210821);
    send(0, 4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 32'h00421021);
    do_clr();
    @(negedge clk);
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_addr", 32'(im_addr), 32'd0);
    chk("clr_we", 32'(im_we), 32'd0);
    chk("clr_count", 32'(wr_count), 32'd0);
    cyc(1);
    im_ready = 1'b1;

    // 6: address wrap on IM_AW=2, then reset mid-drain
    send(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221821);
    send(1, 4'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 32'h00221823);
    send(1, 4'd2, 5'd0, 5'd8, 5'd0, 16'h1234, 26'h0, 32'h34081234);
    send(1, 4'd10, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FFFFFF, 32'h0BFFFFFF);
    send(1, 4'd6, 5'd9, 5'd3, 5'd0, 16'hBEEF, 26'h0, 32'h3C03BEEF);
    cyc(3);
    @(negedge clk);
    chk("wrap_count", 32'(w_wr_count), 32'd5);
    chk("wrap_addr_end", 32'(w_im_addr), 32'd1);
    cyc(1);
    w_im_ready = 1'b0;
    send(1, 4'd0, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 32'h00210821);
    send(1, 4'd0, 5'd2, 5'd2, 5'd2, 16'h0, 26'h0, 32'h00421021);
    send(1, 4'd0, 5'd3, 5'd3, 5'd3, 16'h0, 26'h0, 32'h00631821);
    @(negedge clk);
    chk("wrap_pending_we", 32'(w_im_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("wrap_in_ready_rst", 32'(w_in_ready), 32'd0);
    @(posedge clk); #1;
    wq.delete(); w_exp_addr = 0;
    @(negedge clk);
    chk("wrap_rst_we", 32'(w_im_we), 32'd0);
    chk("wrap_rst_addr", 32'(w_im_addr), 32'd0);
    chk("wrap_rst_count", 32'(w_wr_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    w_im_ready = 1'b1;
    cyc(4);
    @(negedge clk);
    chk("wrap_idle_we", 32'(w_im_we), 32'd0);
    chk("q_empty", 32'(q.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Instruction encoder and instruction-memory loader for the MIPS-Lite3 core. It is the inverse of the core's op/func decoder.
- Accepts symbolic instructions (kind plus fields) over a valid/ready handshake.
- Packs each into a 32-bit MIPS word.
- Buffers words in a small FIFO.
- Writes them sequentially into instruction memory through a backpressured write port.

Used by the test harness and boot loader to fill IM before the core is released.

Parameters:
DEPTH, 4, encoded-word FIFO depth; power of two, at least 2.
IM_AW, 10, instruction-memory word-address width.
BASE_ADDR, 0, first IM word address after reset or clr.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  synchronous reset, active-low.
clr  in  1  synchronous flush: empties the FIFO, sets the address to BASE_ADDR, clears err.
in_valid  in  1  instruction request valid.
in_ready  out  1  request accepted when in_valid && in_ready.
in_kind  in  4  0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 addi, 8 addiu, 9 slt, 10 j, 11 jal, 12 jr; 13-15 illegal.
in_rs  in  5  rs field.
in_rt  in  5  rt field.
in_rd  in  5  rd field.
in_imm  in  16  immediate field.
in_target  in  26  jump target field.
im_we  out  1  write request; high whenever the FIFO is non-empty.
im_ready  in  1  memory accepts the write when im_we && im_ready.
im_addr  out  IM_AW  word address of the current write.
im_wdata  out  32  encoded word (FIFO head).
wr_count  out  16  words written since reset or clr; saturates at 0xFFFF.
err  out  1  sticky flag: an illegal kind was accepted.

Behaviour:
- Reset (rst_n=0 at an edge):
  - FIFO empty, im_we=0, im_addr=BASE_ADDR, wr_count=0, err=0.
  - in_ready=0 while rst_n=0; in_ready=1 on the first cycle after release.
- Encoding, combinational at accept; shamt is always 0:
  - R-type {000000, rs, rt, rd, 00000, func}: addu func 100001, subu 100011, slt 101010.
  - jr: {000000, rs, 00000, 00000, 00000, 001000}; rt/rd inputs ignored.
  - I-type {op, rs, rt, imm}: ori 001101, lw 100011, sw 101011, beq 000100, addi 001000, addiu 101000.
  - addiu uses 101000, which is what this core decodes, not the standard 001001.
  - lui: op 001111 with rs forced to 0.
  - J-type {op, target}: j 000010, jal 000011.
- Input side:
  - in_ready = rst_n && (occupancy < DEPTH). There is no same-cycle pop bypass: a full FIFO deasserts in_ready even if a pop occurs that cycle.
  - A legal accept enqueues one word.
  - An illegal accept completes the handshake, enqueues nothing, and sets err=1.
- Latency: a word accepted at edge N drives im_we=1 and im_wdata from cycle N+1 when the FIFO was empty.
- Output side:
  - im_we, im_addr and im_wdata come directly from registers.
  - On a transfer (im_we && im_ready): pop the head, im_addr += 1 (wraps 2^IM_AW-1 -> 0), wr_count += 1 (saturating).
  - With im_ready=0, im_we, im_addr and im_wdata hold stable.
- Simultaneous push and pop: both occur and occupancy is unchanged; FIFO order is preserved.
- clr:
  - Has priority over push and pop in the same cycle.
  - Accepts nothing and writes nothing that cycle (in_ready=0 during clr).
  - Queued words are discarded.
- Reset mid-drain: pending words are lost, im_we=0 on the next cycle, address returns to BASE_ADDR.
- Pointers: log2(DEPTH) bits plus a wrap bit; full/empty are distinguished by the wrap bit.

Test Plan:
1. addu rs=1 rt=2 rd=3 with im_ready=1 -> next cycle im_we=1, im_addr=0, im_wdata=0x00221821; wr_count=1 after the transfer.
2. ori rs=0 rt=8 imm=0x1234, then lw rs=29 rt=4 imm=0x0008, then addiu rs=1 rt=1 imm=1 -> 0x34081234 @0, 0x8FA40008 @1, 0xA0210001 @2.
3. jal target=0xC00, jr rs=31 rt=5 rd=7, lui rs=9 rt=3 imm=0xBEEF -> 0x0C000C00, 0x03E00008, 0x3C03BEEF.
4. im_ready=0, push 5 back-to-back:
   - in_ready=0 after the 4th accept; the 5th is held.
   - Raise im_ready: writes at addr 0,1,2,3 in order, then the 5th at addr 4.
   - im_wdata stays stable while stalled.
5. Kind 14 accepted -> err=1, no im_we, im_addr unchanged. A following legal sw is still written. clr -> err=0, addr=BASE_ADDR, FIFO empty.
6. Wrap and reset, with IM_AW=2:
   - 5 writes -> addresses 0,1,2,3,0.
   - With 3 words queued and im_ready=0, pulse rst_n=0 -> im_we=0 next cycle, im_addr=0, wr_count=0.
